// File: rtl/bus_arbiter_mux.sv
// N-master shared-bus arbiter with registered one-hot grant, tenure limit and slave-bus mux; grant 1 cycle after request, s_* combinational from grant.
// Masters wait by holding m_req; define ARB_ROUND_ROBIN_EN for rotating priority (fixed lowest-index priority otherwise).
module bus_arbiter_mux #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS-1:0]          m_we,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  output logic [N_MASTERS-1:0]          m_grant,
  output logic                          s_req,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic                          busy
);

  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      owner, owner_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [N_MASTERS-1:0]  grant_nxt;
  logic [N_MASTERS-1:0]  cand;
  logic [IDX_W-1:0]      start;
  logic [IDX_W-1:0]      win;
  logic                  found;
  logic                  hold;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] s, input int k);
    return IDX_W'((int'(s) + k) % N_MASTERS);
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last, last_nxt;
  assign start = wrap_idx(last, 1);
`else
  assign start = '0;
`endif

  // Winner search; the current owner is masked so a handover always moves the bus.
  always_comb begin
    cand  = m_req;
    found = 1'b0;
    win   = '0;
    if (state == GRANT) cand[owner] = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!found && cand[wrap_idx(start, k)]) begin
        found = 1'b1;
        win   = wrap_idx(start, k);
      end
    end
  end

  assign hold = m_req[owner] && ((MAX_BURST == 0) || (cnt < BURST_LIM) || !found);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    grant_nxt = m_grant;
`ifdef ARB_ROUND_ROBIN_EN
    last_nxt  = last;
`endif
    if (state == GRANT && hold) begin
      cnt_nxt = (cnt < BURST_LIM) ? cnt + 1'b1 : cnt;
    end else if (found) begin
      state_nxt      = GRANT;
      owner_nxt      = win;
      cnt_nxt        = CNT_W'(1);
      grant_nxt      = '0;
      grant_nxt[win] = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      last_nxt       = win;
`endif
    end else begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      grant_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      owner   <= '0;
      cnt     <= '0;
      m_grant <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last    <= IDX_W'(N_MASTERS - 1);
`endif
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      cnt     <= cnt_nxt;
      m_grant <= grant_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      last    <= last_nxt;
`endif
    end
  end

  // AND-OR mux keyed on the one-hot grant gives all-zero outputs when idle.
  always_comb begin
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (m_grant[i]) begin
        s_we    = s_we | m_we[i];
        s_addr  = s_addr | m_addr[i*ADDR_W +: ADDR_W];
        s_wdata = s_wdata | m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign s_req = |m_grant;
  assign busy  = (state == GRANT);

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Bench for bus_arbiter_mux: directed scenarios then random traffic, checked every cycle against an integer-level model.
module tb_bus_arbiter_mux;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MB = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    m_req, m_we, m_grant;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic            s_req, s_we, busy;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;

  int checks = 0;
  int errors = 0;
  int m_own  = -1;
  int m_cnt  = 0;
`ifdef ARB_ROUND_ROBIN_EN
  int m_last = N - 1;
`endif

  always #5 clk = ~clk;

  bus_arbiter_mux #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_grant(m_grant), .s_req(s_req), .s_we(s_we),
    .s_addr(s_addr), .s_wdata(s_wdata), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int excl);
    int start;
`ifdef ARB_ROUND_ROBIN_EN
    start = (m_last + 1) % N;
`else
    start = 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (req[(start + k) % N] && ((start + k) % N) != excl) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic take(input int w);
    m_own = w;
    m_cnt = 1;
`ifdef ARB_ROUND_ROBIN_EN
    m_last = w;
`endif
  endtask

  // Ownership model in plain integers: owner index (-1 idle) and tenure length.
  task automatic model_step();
    int w;
    bit others;
    if (!reset_n) begin
      m_own = -1;
      m_cnt = 0;
`ifdef ARB_ROUND_ROBIN_EN
      m_last = N - 1;
`endif
    end else if (m_own < 0) begin
      w = pick(m_req, -1);
      if (w >= 0) take(w);
    end else begin
      w = pick(m_req, m_own);
      others = (w >= 0);
      if (m_req[m_own] && (MB == 0 || m_cnt < MB || !others)) begin
        if (m_cnt < MB) m_cnt++;
      end else if (others) begin
        take(w);
      end else begin
        m_own = -1;
        m_cnt = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    eg = '0;
    if (m_own >= 0) eg[m_own] = 1'b1;
    chk("grant", 64'(m_grant), 64'(eg));
    chk("busy", 64'(busy), 64'(m_own >= 0));
    chk("s_req", 64'(s_req), 64'(m_own >= 0));
    chk("s_we", 64'(s_we), (m_own >= 0) ? 64'(m_we[m_own]) : 64'd0);
    chk("s_addr", 64'(s_addr), (m_own >= 0) ? 64'(m_addr[m_own*AW +: AW]) : 64'd0);
    chk("s_wdata", 64'(s_wdata), (m_own >= 0) ? 64'(m_wdata[m_own*DW +: DW]) : 64'd0);
  endtask

  task automatic tick(input int n);
    for (int c = 0; c < n; c++) begin
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
    end
  endtask

  task automatic rand_data();
    m_we    = 4'($urandom);
    m_addr  = 32'($urandom);
    m_wdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    reset_n = 1'b0;
    m_req   = 4'b1111;
    rand_data();
    tick(3);
    chk("reset_grant", 64'(m_grant), 64'd0);
    chk("reset_addr", 64'(s_addr), 64'd0);

    reset_n = 1'b1;
    tick(1);
    chk("first_grant", 64'(m_grant), 64'b0001);
    tick(40);

    m_req = 4'b0100;
    m_addr[2*AW +: AW] = 8'hA5;
    m_we[2] = 1'b1;
    tick(20);
    chk("single_grant", 64'(m_grant), 64'b0100);
    chk("single_addr", 64'(s_addr), 64'hA5);
    chk("single_we", 64'(s_we), 64'd1);

    m_req = 4'b0010;
    tick(3);
    m_req = 4'b1010;
    tick(2);
    m_req = 4'b1000;
    tick(1);
    chk("handover", 64'(m_grant), 64'b1000);
    m_req = 4'b0000;
    tick(1);
    chk("drop_grant", 64'(m_grant), 64'd0);
    chk("drop_wdata", 64'(s_wdata), 64'd0);

    m_req = 4'b0100;
    tick(4);
    reset_n = 1'b0;
    tick(1);
    chk("midreset_grant", 64'(m_grant), 64'd0);
    reset_n = 1'b1;
    m_req = 4'b1111;
    tick(1);
    chk("restart_grant", 64'(m_grant), 64'b0001);
    tick(10);

    for (int r = 0; r < 1200; r++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) m_req[b] = ~m_req[b];
      if ($urandom_range(0, 3) == 0) rand_data();
      reset_n = ($urandom_range(0, 149) != 0);
      tick(1);
      chk("onehot0", 64'($onehot0(m_grant)), 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
